// File: rtl/tow_referee.sv
// tow_referee: tug-of-war game referee.
//  Turns player press pulses into rope moves on a shared game tick, tracks the
//  light position, decides round wins and scores, and sequences the match
//  IDLE -> PLAY -> HOLD -> (PLAY | OVER).
//
//  Optional feature: define CPU_PLAYER_EN to let an internal 16-bit LFSR play
//  the right side. In that build the right_press port is ignored.
//
// Ports:
//  clk          system clock
//  reset_n      asynchronous active-low reset
//  start        1-cycle pulse, begins a match (IDLE/OVER only)
//  left_press   1-cycle press pulse, left player
//  right_press  1-cycle press pulse, right player
//  tick_ce      1-cycle enable every TICK_DIV clocks
//  lights       one-hot rope position, all-zero in IDLE
//  left_score   rounds won by left
//  right_score  rounds won by right
//  round_win    {left,right} 1-cycle pulse on a round decision
//  match_over   high in OVER
module tow_referee #(
  parameter int unsigned N_LIGHTS   = 9,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned WIN_ROUNDS = 7,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                left_press,
  input  logic                right_press,
  output logic                tick_ce,
  output logic [N_LIGHTS-1:0] lights,
  output logic [3:0]          left_score,
  output logic [3:0]          right_score,
  output logic [1:0]          round_win,
  output logic                match_over
);

  localparam int unsigned POS_W  = $clog2(N_LIGHTS);
  localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [POS_W-1:0]  POS_CENTRE = POS_W'(N_LIGHTS / 2);
  localparam logic [POS_W-1:0]  POS_LEFT   = POS_W'(N_LIGHTS - 1);
  localparam logic [POS_W-1:0]  POS_RIGHT  = '0;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE    = CNT_W'(TICK_DIV - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [3:0]        SCORE_MAX  = 4'(WIN_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [POS_W-1:0]  pos;
  logic [HOLD_W-1:0] hold_cnt;
  logic              lp;
  logic              rp;
  logic              win_left;

  logic              in_play;
  logic              rp_pulse;
  logic              lp_eff;
  logic              rp_eff;
  logic              move_left;
  logic              move_right;
  logic [3:0]        winner_score;

  assign in_play = (state == S_PLAY);

`ifdef CPU_PLAYER_EN
  // LFSR opponent: a press drawn on one tick is pending for the next tick.
  logic [15:0] lfsr;
  logic        cpu_pend;
  logic        unused_right_press;

  assign unused_right_press = right_press;
  assign rp_pulse           = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr     <= 16'hACE1;
      cpu_pend <= 1'b0;
    end else if (tick_ce) begin
      lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      cpu_pend <= in_play && (lfsr[2:0] == 3'b000);
    end
  end

  assign rp_eff = rp | cpu_pend;
`else
  assign rp_pulse = right_press;
  assign rp_eff   = rp | (rp_pulse & in_play);
`endif

  // A press landing on the tick cycle itself is consumed by that tick.
  assign lp_eff       = lp | (left_press & in_play);
  assign move_left    = lp_eff & ~rp_eff;
  assign move_right   = rp_eff & ~lp_eff;
  assign winner_score = win_left ? left_score : right_score;

  // Free-running tick divider; tick_ce is registered one count early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tick_ce  <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
      tick_ce  <= (tick_cnt == CNT_PRE);
    end
  end

  // Round/match sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pos         <= POS_CENTRE;
      hold_cnt    <= '0;
      lp          <= 1'b0;
      rp          <= 1'b0;
      win_left    <= 1'b0;
      left_score  <= '0;
      right_score <= '0;
      round_win   <= '0;
      match_over  <= 1'b0;
      lights      <= '0;
    end else begin
      round_win <= '0;
      lights    <= (state == S_IDLE) ? '0 : (N_LIGHTS'(1) << pos);

      if (tick_ce) begin
        lp <= 1'b0;
        rp <= 1'b0;
      end else if (in_play) begin
        lp <= lp | left_press;
        rp <= rp | rp_pulse;
      end

      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state       <= S_PLAY;
            pos         <= POS_CENTRE;
            left_score  <= '0;
            right_score <= '0;
            match_over  <= 1'b0;
            lp          <= 1'b0;
            rp          <= 1'b0;
          end
        end

        S_PLAY: begin
          if (tick_ce) begin
            if (move_left) begin
              if (pos == POS_LEFT) begin
                state     <= S_HOLD;
                hold_cnt  <= '0;
                win_left  <= 1'b1;
                round_win <= 2'b10;
                if (left_score < SCORE_MAX) left_score <= left_score + 4'd1;
              end else begin
                pos <= pos + POS_W'(1);
              end
            end else if (move_right) begin
              if (pos == POS_RIGHT) begin
                state     <= S_HOLD;
                hold_cnt  <= '0;
                win_left  <= 1'b0;
                round_win <= 2'b01;
                if (right_score < SCORE_MAX) right_score <= right_score + 4'd1;
              end else begin
                pos <= pos - POS_W'(1);
              end
            end
          end
        end

        S_HOLD: begin
          if (tick_ce) begin
            if (hold_cnt == HOLD_LAST) begin
              if (winner_score == SCORE_MAX) begin
                state      <= S_OVER;
                match_over <= 1'b1;
              end else begin
                state <= S_PLAY;
                pos   <= POS_CENTRE;
                lp    <= 1'b0;
                rp    <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee (N_LIGHTS=5, TICK_DIV=4, WIN_ROUNDS=2, HOLD_TICKS=2).
module tb_tow_referee;

  localparam int unsigned NL = 5;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          left_press;
  logic          right_press;
  logic          tick_ce;
  logic [NL-1:0] lights;
  logic [3:0]    left_score;
  logic [3:0]    right_score;
  logic [1:0]    round_win;
  logic          match_over;

  int checks = 0;
  int errors = 0;

  logic [15:0] mlfsr;

  tow_referee #(
    .N_LIGHTS  (NL),
    .TICK_DIV  (4),
    .WIN_ROUNDS(2),
    .HOLD_TICKS(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .left_press (left_press),
    .right_press(right_press),
    .tick_ce    (tick_ce),
    .lights     (lights),
    .left_score (left_score),
    .right_score(right_score),
    .round_win  (round_win),
    .match_over (match_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for the tick_ce cycle and steps past its clock edge.
  task automatic wait_tick();
    int n = 0;
    while (tick_ce !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("tick_timeout", 16'(tick_ce), 16'd1);
    step();
  endtask

  // Presses in a non-tick cycle, then returns just after the deciding tick edge.
  task automatic do_tick(input logic l, input logic r);
    if (tick_ce) step();
    left_press  = l;
    right_press = r;
    step();
    left_press  = 1'b0;
    right_press = 1'b0;
    wait_tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    left_press  = 1'b0;
    right_press = 1'b0;
    mlfsr       = 16'hACE1;
    step();
    step();
    chk("rst_lights", 16'(lights), 16'h0);
    chk("rst_tick", 16'(tick_ce), 16'h0);
    reset_n = 1'b1;

    // Test 1: tick_ce on cycles 3, 7, 11 after reset release.
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("tick_c%0d", c), 16'(tick_ce), (c == 3 || c == 7 || c == 11) ? 16'd1 : 16'd0);
      if (tick_ce) mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
      step();
    end
    chk("idle_lights", 16'(lights), 16'h0);
    chk("idle_lscore", 16'(left_score), 16'h0);
    chk("idle_rscore", 16'(right_score), 16'h0);
    chk("idle_over", 16'(match_over), 16'h0);

`ifdef CPU_PLAYER_EN
    // Test 6: LFSR opponent, right_press port held high and ignored.
    begin
      logic [2:0] mpos = 3'd2;
      logic       mrp  = 1'b0;
      logic       won  = 1'b0;
      right_press = 1'b1;
      pulse_start();
      for (int t = 0; t < 40 && !won; t++) begin
        int n = 0;
        while (tick_ce !== 1'b1 && n < 12) begin
          step();
          n++;
        end
        chk("cpu_tick_timeout", 16'(tick_ce), 16'd1);
        if (mrp) begin
          if (mpos == 3'd0) won = 1'b1;
          else mpos = mpos - 3'd1;
        end
        mrp   = (mlfsr[2:0] == 3'b000);
        mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        step();
        step();
        chk($sformatf("cpu_lights_t%0d", t), 16'(lights), 16'(5'b00001 << mpos));
      end
      right_press = 1'b0;
    end
`else
    // Test 2: three left presses, left wins the round.
    pulse_start();
    step();
    chk("play_centre", 16'(lights), 16'b00100);
    do_tick(1'b1, 1'b0);
    step();
    chk("l_move1", 16'(lights), 16'b01000);
    do_tick(1'b1, 1'b0);
    step();
    chk("l_move2", 16'(lights), 16'b10000);
    do_tick(1'b1, 1'b0);
    chk("win1_pulse", 16'(round_win), 16'b10);
    chk("win1_lscore", 16'(left_score), 16'd1);
    step();
    chk("win1_pulse_end", 16'(round_win), 16'b00);
    chk("hold_lights", 16'(lights), 16'b10000);
    wait_tick();
    chk("hold_lights2", 16'(lights), 16'b10000);
    wait_tick();
    step();
    chk("hold_back_centre", 16'(lights), 16'b00100);
    chk("hold_not_over", 16'(match_over), 16'd0);

    // Test 3: both players in the same tick window cancel out.
    do_tick(1'b1, 1'b1);
    chk("both_no_win", 16'(round_win), 16'b00);
    step();
    chk("both_lights", 16'(lights), 16'b00100);

    // Test 4: second left win ends the match.
    do_tick(1'b1, 1'b0);
    do_tick(1'b1, 1'b0);
    do_tick(1'b1, 1'b0);
    chk("win2_pulse", 16'(round_win), 16'b10);
    chk("win2_lscore", 16'(left_score), 16'd2);
    chk("win2_rscore", 16'(right_score), 16'd0);
    wait_tick();
    wait_tick();
    chk("over_flag", 16'(match_over), 16'd1);
    step();
    chk("over_lights", 16'(lights), 16'b10000);
    do_tick(1'b1, 1'b0);
    chk("over_no_pulse", 16'(round_win), 16'b00);
    chk("over_lscore_frozen", 16'(left_score), 16'd2);
    do_tick(1'b0, 1'b1);
    step();
    chk("over_lights_frozen", 16'(lights), 16'b10000);
    chk("over_rscore_frozen", 16'(right_score), 16'd0);
    chk("over_still", 16'(match_over), 16'd1);
    pulse_start();
    chk("restart_over", 16'(match_over), 16'd0);
    chk("restart_lscore", 16'(left_score), 16'd0);
    step();
    chk("restart_lights", 16'(lights), 16'b00100);

    // Test 5: right wins a round, then reset mid-tick in HOLD.
    do_tick(1'b0, 1'b1);
    step();
    chk("r_move1", 16'(lights), 16'b00010);
    do_tick(1'b0, 1'b1);
    do_tick(1'b0, 1'b1);
    chk("rwin_pulse", 16'(round_win), 16'b01);
    chk("rwin_rscore", 16'(right_score), 16'd1);
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_lights", 16'(lights), 16'h0);
    chk("arst_rscore", 16'(right_score), 16'h0);
    chk("arst_tick", 16'(tick_ce), 16'h0);
    chk("arst_over", 16'(match_over), 16'h0);
    step();
    reset_n = 1'b1;
    do_tick(1'b1, 1'b0);
    step();
    chk("post_rst_idle_lights", 16'(lights), 16'h0);
    chk("post_rst_lscore", 16'(left_score), 16'h0);
    pulse_start();
    step();
    chk("post_rst_play", 16'(lights), 16'b00100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
